// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, ACKed
// write reception and host-fed read transmission. SCL is never stretched.
module i2c_slave #(
  parameter int FILTER_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [6:0] i_own_addr,
  input  logic [7:0] i_miso_data,
  output logic       o_need_data,
  output logic [7:0] o_mosi_data,
  output logic       o_data_ready,
  output logic       o_rw,
  output logic       o_busy,
  output logic       o_stop,
  input  logic       i_scl,
  inout  wire        io_sda
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE_BYTE, WRITE_ACK, READ_BYTE, READ_ACK, WAIT_STOP
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0] line_raw, line_filt, line_filt_d;
  assign line_raw = {io_sda, i_scl};

  // Index 0 is SCL, index 1 is SDA; both see identical latency so START/STOP
  // ordering relative to SCL is preserved.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0] sync_reg;
      logic [3:0] cnt_reg;
      logic       filt_reg, filt_d_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sync_reg   <= 2'b11;
          cnt_reg    <= '0;
          filt_reg   <= 1'b1;
          filt_d_reg <= 1'b1;
        end else begin
          sync_reg   <= {sync_reg[0], line_raw[gi]};
          filt_d_reg <= filt_reg;
          if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
      end

      assign line_filt[gi]   = filt_reg;
      assign line_filt_d[gi] = filt_d_reg;
    end
  endgenerate

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = line_filt[0];
  assign sda_f     = line_filt[1];
  assign scl_rise  = scl_f & ~line_filt_d[0];
  assign scl_fall  = ~scl_f & line_filt_d[0];
  assign start_det = ~sda_f & line_filt_d[1] & scl_f;
  assign stop_det  = sda_f & ~line_filt_d[1] & scl_f;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic       phase_reg, phase_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] mosi_reg, mosi_next;
  logic       rw_reg, rw_next, busy_reg, busy_next;
  logic       need_reg, need_next, ready_reg, ready_next, stop_reg, stop_next;

  // On the 8th rise shift_reg holds the seven address bits, sda_f is R/W.
  logic byte_done, addr_hit;
  assign byte_done = scl_rise && (bit_cnt_reg == 3'd7);
  assign addr_hit  = i_enable && (shift_reg == i_own_addr) && (|shift_reg);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (stop_det) begin
      state_next = IDLE;
    end else if (start_det) begin
      state_next = ADDR;
    end else begin
      case (state_reg)
        ADDR:       if (byte_done) state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:   if (scl_fall && phase_reg) state_next = rw_reg ? READ_BYTE : WRITE_BYTE;
        WRITE_BYTE: if (byte_done) state_next = WRITE_ACK;
        WRITE_ACK:  if (scl_fall && phase_reg) state_next = WRITE_BYTE;
        READ_BYTE:  if (scl_fall && bit_cnt_reg == 3'd7) state_next = READ_ACK;
        READ_ACK: begin
          if (scl_rise && sda_f)               state_next = WAIT_STOP;
          else if (scl_fall && phase_reg)      state_next = READ_BYTE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    phase_next   = phase_reg;
    sda_oe_next  = sda_oe_reg;
    mosi_next    = mosi_reg;
    rw_next      = rw_reg;
    busy_next    = busy_reg;
    need_next    = 1'b0;
    ready_next   = 1'b0;
    stop_next    = 1'b0;
    if (stop_det) begin
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
      stop_next   = 1'b1;
      phase_next  = 1'b0;
    end else if (start_det) begin
      sda_oe_next  = 1'b0;
      bit_cnt_next = 3'd0;
      phase_next   = 1'b0;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = {shift_reg[5:0], sda_f};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (byte_done && addr_hit) begin
            rw_next   = sda_f;
            busy_next = 1'b1;
          end
        end
        ADDR_ACK: begin
          if (scl_rise && phase_reg && rw_reg) need_next = 1'b1;
          if (scl_fall) begin
            phase_next = ~phase_reg;
            if (!phase_reg) begin
              sda_oe_next = 1'b1;
            end else if (rw_reg) begin
              shift_next  = i_miso_data[6:0];
              sda_oe_next = ~i_miso_data[7];
            end else begin
              sda_oe_next = 1'b0;
            end
          end
        end
        WRITE_BYTE: if (scl_rise) begin
          shift_next   = {shift_reg[5:0], sda_f};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (byte_done) begin
            mosi_next  = {shift_reg, sda_f};
            ready_next = 1'b1;
            phase_next = 1'b0;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          sda_oe_next = ~phase_reg;
          phase_next  = ~phase_reg;
        end
        READ_BYTE: if (scl_fall) begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            sda_oe_next = 1'b0;
            phase_next  = 1'b0;
          end else begin
            sda_oe_next = ~shift_reg[6];
            shift_next  = {shift_reg[5:0], 1'b0};
          end
        end
        READ_ACK: begin
          if (scl_rise && !sda_f) begin
            need_next  = 1'b1;
            phase_next = 1'b1;
          end else if (scl_fall && phase_reg) begin
            shift_next  = i_miso_data[6:0];
            sda_oe_next = ~i_miso_data[7];
            phase_next  = 1'b0;
          end
        end
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      phase_reg   <= 1'b0;
      sda_oe_reg  <= 1'b0;
      mosi_reg    <= '0;
      rw_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      need_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      stop_reg    <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      phase_reg   <= phase_next;
      sda_oe_reg  <= sda_oe_next;
      mosi_reg    <= mosi_next;
      rw_reg      <= rw_next;
      busy_reg    <= busy_next;
      need_reg    <= need_next;
      ready_reg   <= ready_next;
      stop_reg    <= stop_next;
    end
  end

  assign io_sda       = sda_oe_reg ? 1'b0 : 1'bz;
  assign o_need_data  = need_reg;
  assign o_mosi_data  = mosi_reg;
  assign o_data_ready = ready_reg;
  assign o_rw         = rw_reg;
  assign o_busy       = busy_reg;
  assign o_stop       = stop_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; received bytes are checked through a
// scoreboard queue, read bytes are supplied by a host model on o_need_data.
module tb_i2c_slave;
  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [6:0] own = 7'h3C;
  logic [7:0] miso = 8'h00;
  logic       need, ready, rw, busy, stp;
  logic [7:0] mosi;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.FILTER_LEN(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_own_addr(own),
    .i_miso_data(miso), .o_need_data(need), .o_mosi_data(mosi),
    .o_data_ready(ready), .o_rw(rw), .o_busy(busy), .o_stop(stp),
    .i_scl(scl_m), .io_sda(sda)
  );

  int n_checks = 0;
  int n_errors = 0;
  int need_cnt = 0, stop_cnt = 0, ready_cnt = 0, dut_low_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] host_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard pop, host data supply and bus observation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready) begin
        ready_cnt++;
        if (exp_q.size() == 0) check("unexpected_data_ready", 32'(mosi), 32'hFFFF_FFFF);
        else check("mosi_data", 32'(mosi), 32'(exp_q.pop_front()));
      end
      if (need) begin
        need_cnt++;
        miso = (host_q.size() != 0) ? host_q.pop_front() : 8'h00;
      end
      if (stp) stop_cnt++;
      if (!m_low && sda === 1'b0) dut_low_cnt++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_low = ~b;
    if (glitch) begin
      wait_cyc(Q / 2); scl_m = 1'b1; wait_cyc(1); scl_m = 1'b0; wait_cyc(Q / 2);
    end else wait_cyc(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wait_cyc(Q); m_low = ~m_low; wait_cyc(1); m_low = ~m_low; wait_cyc(Q);
    end else wait_cyc(2 * Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(Q); b = sda;
    wait_cyc(Q); scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack, 1'b0);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    m_low = 1'b1; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    m_low = 1'b0; wait_cyc(2 * Q);
  endtask

  typedef struct {
    logic [6:0] own;
    logic       en;
    logic [6:0] addr;
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         low0, st0, rdy0, nd0;

    vecs[0] = '{7'h3C, 1'b1, 7'h3C, 2, 8'hA5, 8'h5A, 1'b1};
    vecs[1] = '{7'h3C, 1'b1, 7'h3D, 1, 8'h12, 8'h00, 1'b0};
    vecs[2] = '{7'h3C, 1'b0, 7'h3C, 1, 8'h34, 8'h00, 1'b0};
    vecs[3] = '{7'h7F, 1'b1, 7'h7F, 1, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{7'h00, 1'b1, 7'h00, 1, 8'h56, 8'h00, 1'b0};
    vecs[5] = '{7'h01, 1'b1, 7'h01, 2, 8'hFF, 8'h80, 1'b1};

    wait_cyc(4);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rw", 32'(rw), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_pulses", 32'({need, ready, stp}), 32'd0);
    check("reset_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    wait_cyc(10);

    // Table-driven write / address-match cases.
    for (int v = 0; v < 6; v++) begin
      own = vecs[v].own; en = vecs[v].en;
      low0 = dut_low_cnt; st0 = stop_cnt; rdy0 = ready_cnt;
      i2c_start();
      send_byte({vecs[v].addr, 1'b0}, 1'b0, ack);
      check("addr_ack", 32'(ack), 32'(vecs[v].exp_ack));
      if (vecs[v].exp_ack) begin
        check("wr_rw", 32'(rw), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        exp_q.push_back(vecs[v].d0);
        send_byte(vecs[v].d0, 1'b0, ack);
        check("wr_ack0", 32'(ack), 32'd1);
        if (vecs[v].nb == 2) begin
          exp_q.push_back(vecs[v].d1);
          send_byte(vecs[v].d1, 1'b0, ack);
          check("wr_ack1", 32'(ack), 32'd1);
        end
      end else begin
        send_byte(vecs[v].d0, 1'b0, ack);
        check("nack_data", 32'(ack), 32'd0);
        check("nack_busy", 32'(busy), 32'd0);
        check("nack_sda_never_low", 32'(dut_low_cnt - low0), 32'd0);
      end
      i2c_stop();
      wait_cyc(10);
      check("stop_pulse", 32'(stop_cnt - st0), 32'd1);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("ready_count", 32'(ready_cnt - rdy0), vecs[v].exp_ack ? 32'(vecs[v].nb) : 32'd0);
      $display("vec %0d: own %h en %0d addr %h ack %0d", v, vecs[v].own, vecs[v].en, vecs[v].addr, ack);
    end

    // Two-byte read: ACK then NACK.
    own = 7'h3C; en = 1'b1;
    host_q.push_back(8'hC3); host_q.push_back(8'h81);
    nd0 = need_cnt;
    i2c_start();
    send_byte({7'h3C, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    check("rd_rw", 32'(rw), 32'd1);
    recv_byte(d, 1'b1);
    check("rd_byte0", 32'(d), 32'hC3);
    recv_byte(d, 1'b0);
    check("rd_byte1", 32'(d), 32'h81);
    check("rd_released", 32'(sda), 32'd1);
    check("rd_need_count", 32'(need_cnt - nd0), 32'd2);
    i2c_stop();
    wait_cyc(10);
    check("rd_busy_after_stop", 32'(busy), 32'd0);
    $display("read: bytes c3 81 need pulses %0d", need_cnt - nd0);

    // Write, repeated START, read.
    exp_q.push_back(8'h11);
    host_q.push_back(8'h22);
    i2c_start();
    send_byte({7'h3C, 1'b0}, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack);
    check("rs_wr_ack", 32'(ack), 32'd1);
    check("rs_rw_before", 32'(rw), 32'd0);
    i2c_start();
    send_byte({7'h3C, 1'b1}, 1'b0, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'd1);
    check("rs_rw_after", 32'(rw), 32'd1);
    recv_byte(d, 1'b0);
    check("rs_rd_byte", 32'(d), 32'h22);
    check("rs_mosi", 32'(mosi), 32'h11);
    i2c_stop();
    wait_cyc(10);
    $display("repeated start: wrote 11 read %h", d);

    // Single-cycle glitches on SCL (low phase) and SDA (high phase).
    st0 = stop_cnt; rdy0 = ready_cnt;
    exp_q.push_back(8'h96);
    i2c_start();
    send_byte({7'h3C, 1'b0}, 1'b0, ack);
    send_byte(8'h96, 1'b1, ack);
    check("gl_ack", 32'(ack), 32'd1);
    check("gl_no_stop", 32'(stop_cnt - st0), 32'd0);
    i2c_stop();
    wait_cyc(10);
    check("gl_ready_count", 32'(ready_cnt - rdy0), 32'd1);
    check("gl_mosi", 32'(mosi), 32'h96);
    check("gl_stop", 32'(stop_cnt - st0), 32'd1);
    $display("glitch: byte %h", mosi);

    // Asynchronous reset while the target drives a 0 read bit.
    host_q.push_back(8'h00);
    i2c_start();
    send_byte({7'h3C, 1'b1}, 1'b0, ack);
    check("rst_addr_ack", 32'(ack), 32'd1);
    check("rst_bit7_driven", 32'(sda), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_sda_released", 32'(sda), 32'd1);
    check("rst_outputs", 32'({need, ready, rw, busy, stp}), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    i2c_stop();
    exp_q.push_back(8'h42);
    i2c_start();
    send_byte({7'h3C, 1'b0}, 1'b0, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h42, 1'b0, ack);
    check("post_rst_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_cyc(10);
    $display("reset recovery: byte %h", mosi);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target (responder), the counterpart of the team's i2c_master.
- Oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, and matches the own address.
- ACKs and shifts in write bytes; shifts out read bytes supplied by the host logic through a need-data/data-ready handshake.
- No clock stretching; SCL is input only; SDA is open-drain.

Parameters:
- FILTER_LEN, 3: consecutive identical synchronized samples required before the filtered SCL/SDA level changes (1..15).

Ports:
- i_clk  input  1  system clock; all logic on its rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  1 = respond to own address; sampled at address compare
- i_own_addr  input  7  own 7-bit address
- i_miso_data  input  8  byte to transmit to master during a read
- o_need_data  output  1  one-cycle pulse: present next read byte on i_miso_data
- o_mosi_data  output  8  last byte received from master
- o_data_ready  output  1  one-cycle pulse: o_mosi_data updated
- o_rw  output  1  R/W bit of the current addressed transfer (1 = read)
- o_busy  output  1  1 while addressed (ADDR_ACK through end of transfer)
- o_stop  output  1  one-cycle pulse on every STOP detected
- i_scl  input  1  I2C clock from bus
- io_sda  inout  1  I2C data; driven 0 or released (z), never driven 1

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE, SDA released, filters preset to 1.
  - o_mosi_data=0, o_need_data=0, o_data_ready=0, o_rw=0, o_busy=0, o_stop=0.
  - Effective immediately, including mid-transfer.
- Input conditioning:
  - 2-flop synchronizer per line, then a FILTER_LEN glitch filter.
  - Edge events (scl_rise, scl_fall, sda_rise, sda_fall) come from filtered value vs its one-cycle-delayed copy.
  - Event latency from pin: 2 + FILTER_LEN cycles.
- Bus conditions:
  - START = sda_fall while filtered SCL=1. STOP = sda_rise while filtered SCL=1.
  - START in any state: release SDA, bit counter=0, go to ADDR (repeated START supported).
  - STOP in any state: release SDA, o_busy=0, pulse o_stop, go to IDLE.
  - START/STOP take priority over data handling in the same cycle.
- Data timing:
  - Bits are sampled MSB first on scl_rise.
  - The SDA drive value changes only on scl_fall, in the same cycle as the event.
- State machine:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. On the 8th scl_rise compare bits[7:1] with i_own_addr.
    - Match and i_enable=1: latch o_rw=bit0, o_busy=1, go to ADDR_ACK.
    - Otherwise go to WAIT_STOP with SDA released (NACK).
    - General call (0x00) is not recognized.
  - ADDR_ACK:
    - Next scl_fall: drive SDA=0.
    - If o_rw=1, pulse o_need_data on the ACK-bit scl_rise.
    - Following scl_fall: if o_rw=0 release SDA and go to WRITE_BYTE.
    - If o_rw=1: load shift register from i_miso_data, drive bit7 (0 → drive low, 1 → release), go to READ_BYTE.
  - WRITE_BYTE:
    - On the 8th scl_rise: o_mosi_data=byte, pulse o_data_ready, go to WRITE_ACK.
  - WRITE_ACK:
    - scl_fall: drive 0. Next scl_fall: release, go to WRITE_BYTE.
    - Every write byte is ACKed.
  - READ_BYTE:
    - On each scl_fall after bits 7..1, drive the next lower bit.
    - After the scl_fall ending bit 0, release SDA and go to READ_ACK.
  - READ_ACK: on scl_rise sample SDA.
    - 0 (master ACK): pulse o_need_data. Next scl_fall: load i_miso_data, drive bit7, go to READ_BYTE.
    - 1 (master NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START/STOP leave it.
- Handshake: i_miso_data must be stable from the o_need_data pulse until the next scl_fall; it is sampled exactly on that cycle.
- Counters: 3-bit bit counter wraps 7→0 at each byte boundary; no byte-count limit.
- i_enable or i_own_addr changes mid-transfer: no effect until the next address phase.

Test Plan:
- Master writes addr 0x3C+W, bytes 0xA5,0x5A, STOP, own addr 0x3C → ACK on 3 ACK bits; o_data_ready pulses twice with o_mosi_data 0xA5 then 0x5A; o_rw=0; o_stop pulse; o_busy returns 0.
- Master reads addr 0x3C+R, 2 bytes (ACK, NACK), host supplies 0xC3 then 0x81 on o_need_data → bus bits 11000011, 10000001; o_need_data pulses 2 times (address ACK, master ACK); SDA released after NACK.
- Address 0x3D while own 0x3C, or i_enable=0 → SDA never driven low; o_busy stays 0; o_stop still pulses at STOP.
- Write 0x3C+W, byte 0x11, repeated START, 0x3C+R, read 0x22, NACK, STOP → o_mosi_data=0x11; o_rw goes 0→1; bus read byte 0x22.
- 1-cycle glitches on SCL/SDA during a byte (FILTER_LEN=3) → no extra bit, no spurious START/STOP, received byte unchanged.
- i_rst_n asserted mid-read while driving a 0 bit → io_sda released immediately (async); all outputs 0; next START+address handled normally.
